stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer.sv | 128 ++++++++++++
 tb/tb_stage_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - launches decoder stages one at a time per granule and waits for each to finish.
// Optional watchdog on the WAIT state enabled by defining STAGE_SEQ_TIMEOUT_EN.
module stage_sequencer #(
  parameter int NUM_STAGES     = 8,
  parameter int NUM_GRANULES   = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  output logic [NUM_STAGES-1:0] stage_ready,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [2:0]            active_stage,
  output logic                  granule_index,
  output logic                  frame_busy,
  output logic                  frame_done,
  output logic                  timeout_err,
  output logic [2:0]            timeout_stage
);

  if (NUM_STAGES < 2 || NUM_STAGES > 8 || NUM_GRANULES < 1 || NUM_GRANULES > 2 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("stage_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  state_t                  state, state_d;
  logic [2:0]              stage_d;
  logic                    granule_d;
  logic [NUM_STAGES-1:0]   ready_d;
  logic                    done_hit;
  logic                    expire;

  // Only the done bit of the stage being awaited counts, and only while waiting.
  assign done_hit = (state == WAIT) &&
                    |(stage_done & (NUM_STAGES'(1) << active_stage));

  always_comb begin
    state_d   = state;
    stage_d   = active_stage;
    granule_d = granule_index;
    ready_d   = '0;
    unique case (state)
      IDLE: begin
        if (frame_start) begin
          state_d   = LAUNCH;
          stage_d   = 3'd0;
          granule_d = 1'b0;
          ready_d   = NUM_STAGES'(1);
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (done_hit) begin
          if (active_stage != 3'(NUM_STAGES - 1)) begin
            stage_d = active_stage + 3'd1;
            state_d = LAUNCH;
          end else if (granule_index != 1'(NUM_GRANULES - 1)) begin
            granule_d = granule_index + 1'b1;
            stage_d   = 3'd0;
            state_d   = LAUNCH;
          end else begin
            state_d = DONE;
          end
          if (state_d == LAUNCH) ready_d = NUM_STAGES'(1) << stage_d;
        end else if (expire) begin
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      stage_ready   <= '0;
      active_stage  <= 3'd0;
      granule_index <= 1'b0;
      frame_busy    <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state         <= state_d;
      stage_ready   <= ready_d;
      active_stage  <= stage_d;
      granule_index <= granule_d;
      frame_busy    <= (state_d != IDLE);
      frame_done    <= (state_d == DONE);
    end
  end

`ifdef STAGE_SEQ_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // A done arriving in the expiry cycle wins over the watchdog.
  assign expire = (state == WAIT) && !done_hit &&
                  (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt      <= 16'd0;
      timeout_err   <= 1'b0;
      timeout_stage <= 3'd0;
    end else begin
      if (state == LAUNCH) begin
        wait_cnt <= 16'd0;
      end else if (state == WAIT && !done_hit) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (state == IDLE && frame_start) begin
        timeout_err   <= 1'b0;
        timeout_stage <= 3'd0;
      end else if (expire) begin
        timeout_err   <= 1'b1;
        timeout_stage <= active_stage;
      end
    end
  end
`else
  assign expire        = 1'b0;
  assign timeout_err   = 1'b0;
  assign timeout_stage = 3'd0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - directed scoreboard bench for stage_sequencer.
// Timeout scenarios run when STAGE_SEQ_TIMEOUT_EN is defined; otherwise the indefinite wait is checked.
module tb_stage_sequencer;
  localparam int NS = 8;
  localparam int NG = 2;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic [NS-1:0] stage_ready;
  logic [NS-1:0] stage_done;
  logic [NS-1:0] resp_done;
  logic [NS-1:0] man_done;
  logic [2:0]    active_stage;
  logic          granule_index;
  logic          frame_busy;
  logic          frame_done;
  logic          timeout_err;
  logic [2:0]    timeout_stage;

  int   n_tests = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   ready_cnt = 0;
  bit   resp_en = 1'b0;
  int   skip_stage = -1;
  logic [3:0] exp_q[$];

  stage_sequencer #(.NUM_STAGES(NS), .NUM_GRANULES(NG), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .stage_ready(stage_ready),
    .stage_done(stage_done), .active_stage(active_stage), .granule_index(granule_index),
    .frame_busy(frame_busy), .frame_done(frame_done), .timeout_err(timeout_err),
    .timeout_stage(timeout_stage)
  );

  always #5 clk = ~clk;
  assign stage_done = resp_done | man_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stage model: answers each launch with a done pulse three cycles later.
  initial begin : responder
    int rc;
    int ri;
    rc = 0;
    ri = 0;
    resp_done = '0;
    forever begin
      @(negedge clk);
      resp_done = '0;
      if (!resp_en) rc = 0;
      if (rc > 0) begin
        rc--;
        if (rc == 0) resp_done = NS'(1) << ri;
      end
      if (resp_en && |stage_ready) begin
        for (int i = 0; i < NS; i++) if (stage_ready[i]) ri = i;
        if (ri == skip_stage) skip_stage = -1;
        else rc = 3;
      end
    end
  end

  initial begin : monitor
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (frame_done) done_cnt++;
      if (|stage_ready) begin
        ready_cnt++;
        if (exp_q.size() == 0) begin
          check("ready_unexpected", 32'(stage_ready), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ready_onehot", 32'(stage_ready), 32'(NS'(1) << e[2:0]));
          check("ready_granule", 32'(granule_index), 32'(e[3]));
          check("ready_active", 32'(active_stage), 32'(e[2:0]));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_frame(input int ng);
    for (int g = 0; g < ng; g++)
      for (int s = 0; s < NS; s++) exp_q.push_back({1'(g), 3'(s)});
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("start_ready0", 32'(stage_ready), 32'd1);
    check("start_busy", 32'(frame_busy), 32'd1);
  endtask

  task automatic wait_ready(input int s, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (stage_ready[s]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check($sformatf("wait_ready_s%0d", s), 32'(ok), 32'd1);
  endtask

  task automatic finish_frame(input string tag, input int exp_done);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
    check({tag, "_busy_in_done"}, 32'(frame_busy), 32'd1);
    tick();
    check({tag, "_busy_after"}, 32'(frame_busy), 32'd0);
    check({tag, "_done_pulse"}, 32'(frame_done), 32'd0);
    check({tag, "_done_count"}, 32'(done_cnt), 32'(exp_done));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, 32'(stage_ready), 32'd0);
    check({tag, "_active"}, 32'(active_stage), 32'd0);
    check({tag, "_granule"}, 32'(granule_index), 32'd0);
    check({tag, "_busy"}, 32'(frame_busy), 32'd0);
    check({tag, "_fdone"}, 32'(frame_done), 32'd0);
    check({tag, "_terr"}, 32'(timeout_err), 32'd0);
    check({tag, "_tstage"}, 32'(timeout_stage), 32'd0);
  endtask

  initial begin : stimulus
    int frames;
    bit found;
    rst = 1'b1;
    frame_start = 1'b0;
    man_done = '0;
    frames = 0;
    tick(3);
    check_zero("reset");
    rst = 1'b0;
    resp_en = 1'b1;
    tick(6);

    // Full frame; frame_start re-asserted while stage 4 is launched is ignored.
    push_frame(NG);
    start_frame();
    wait_ready(4, 60);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    frames++;
    finish_frame("frame1", frames);
    check("frame1_ready_count", 32'(ready_cnt), 32'd16);

    // Stray done bits and a done during LAUNCH must not advance stage 2.
    skip_stage = 2;
    push_frame(NG);
    start_frame();
    wait_ready(2, 60);
    man_done = 8'h24;
    tick();
    man_done = 8'h20;
    tick();
    man_done = '0;
    check("stray_active", 32'(active_stage), 32'd2);
    check("stray_ready", 32'(stage_ready), 32'd0);
    tick(4);
    check("stray_active_hold", 32'(active_stage), 32'd2);
    check("stray_busy", 32'(frame_busy), 32'd1);
    man_done = 8'h04;
    tick();
    man_done = '0;
    check("stray_advance", 32'(stage_ready), 32'h08);
    frames++;
    finish_frame("stray", frames);

`ifdef STAGE_SEQ_TIMEOUT_EN
    skip_stage = 3;
    for (int s = 0; s < 4; s++) exp_q.push_back({1'b0, 3'(s)});
    start_frame();
    wait_ready(3, 60);
    tick(TO);
    check("to_pre_err", 32'(timeout_err), 32'd0);
    check("to_pre_busy", 32'(frame_busy), 32'd1);
    tick();
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_stage", 32'(timeout_stage), 32'd3);
    check("to_busy", 32'(frame_busy), 32'd0);
    check("to_fdone", 32'(frame_done), 32'd0);
    tick();
    check("to_done_count", 32'(done_cnt), 32'(frames));
    check("to_err_sticky", 32'(timeout_err), 32'd1);
    push_frame(NG);
    start_frame();
    check("to_err_cleared", 32'(timeout_err), 32'd0);
    check("to_stage_cleared", 32'(timeout_stage), 32'd0);
    frames++;
    finish_frame("to_restart", frames);

    // Done in the last permitted WAIT cycle beats the watchdog.
    skip_stage = 3;
    push_frame(NG);
    start_frame();
    wait_ready(3, 60);
    tick(TO);
    man_done = 8'h08;
    tick();
    man_done = '0;
    check("edge_next_ready", 32'(stage_ready), 32'h10);
    check("edge_no_err", 32'(timeout_err), 32'd0);
    frames++;
    finish_frame("edge", frames);
    check("edge_err_final", 32'(timeout_err), 32'd0);
`else
    skip_stage = 3;
    push_frame(NG);
    start_frame();
    wait_ready(3, 60);
    tick(40);
    check("hold_active", 32'(active_stage), 32'd3);
    check("hold_busy", 32'(frame_busy), 32'd1);
    check("hold_err", 32'(timeout_err), 32'd0);
    check("hold_tstage", 32'(timeout_stage), 32'd0);
    man_done = 8'h08;
    tick();
    man_done = '0;
    check("hold_next_ready", 32'(stage_ready), 32'h10);
    frames++;
    finish_frame("hold", frames);
`endif

    // Reset while waiting on stage 6 of granule 1, then a clean restart.
    push_frame(NG);
    start_frame();
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (granule_index && active_stage == 3'd6 && stage_ready == '0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("rst_wait_found", 32'(found), 32'd1);
    rst = 1'b1;
    resp_en = 1'b0;
    tick();
    rst = 1'b0;
    check_zero("mid_rst");
    check("mid_rst_q_left", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    tick(2);
    resp_en = 1'b1;
    push_frame(NG);
    start_frame();
    frames++;
    finish_frame("after_rst", frames);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
